// File: rtl/load_data_unit_pkg.sv
// Shared encodings for the load data unit: sign_mask size codes, sign bit position, FSM states.
// Pure definitions: no timing and no flow control.
package load_data_unit_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam int         SIGN_BIT  = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD0   = 3'd1,
    ST_WAIT0 = 3'd2,
    ST_RD1   = 3'd3,
    ST_WAIT1 = 3'd4,
    ST_RESP  = 3'd5
  } state_t;

  // sign_mask[1] set means word, whatever sign_mask[0] holds
  function automatic logic is_misaligned(input logic [2:0] mask, input logic [1:0] off);
    if (mask[1])
      return off != 2'b00;
    if (mask[1:0] == SIZE_HALF)
      return off[0];
    return 1'b0;
  endfunction

  function automatic logic needs_split(input logic [2:0] mask, input logic [1:0] off);
    if (mask[1])
      return off != 2'b00;
    if (mask[1:0] == SIZE_HALF)
      return off == 2'b11;
    return 1'b0;
  endfunction

endpackage

// File: rtl/load_data_extract.sv
// Picks the byte/halfword/word at the byte offset out of {word1,word0} and sign/zero extends it.
// Purely combinational, no backpressure.
module load_data_extract
  import load_data_unit_pkg::*;
(
  input  logic [31:0] word0,
  input  logic [31:0] word1,
  input  logic [1:0]  offset,
  input  logic [2:0]  sign_mask,
  output logic [31:0] result
);

  logic [31:0] shifted;
  logic        sx;

  always_comb begin
    shifted = 32'({word1, word0} >> {offset, 3'b000});
    sx      = sign_mask[SIGN_BIT];
    case (sign_mask[1:0])
      SIZE_BYTE: result = {{24{sx & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: result = {{16{sx & shifted[15]}}, shifted[15:0]};
      default:   result = shifted;
    endcase
  end

endmodule

// File: rtl/load_data_unit.sv
// Sequential LB/LBU/LH/LHU/LW unit; split misaligned service enabled by LOAD_MISALIGN_SPLIT_EN.
// Latency: done_o 2+MEM_LATENCY cycles after accept (split 3+2*MEM_LATENCY, unserviced misaligned 2).
// Backpressure: busy_o outside IDLE; requests seen while busy are dropped, not queued.
module load_data_unit
  import load_data_unit_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [2:0]            sign_mask_i,
  output logic                  mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [31:0]           mem_rdata_i,
  output logic [31:0]           rdata_o,
  output logic                  done_o,
  output logic                  busy_o,
  output logic                  misaligned_o
);

`ifdef LOAD_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  localparam logic [2:0] LAT_M1 = 3'(MEM_LATENCY - 1);

  state_t                state, state_nxt;
  logic [2:0]            cnt, cnt_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, rd_addr0, rd_addr1;
  logic [2:0]            mask_q;
  logic                  mis_q;
  logic [31:0]           word0_q, word1_q;
  logic                  accept, cap0, cap1, done_nxt, split, req_mis;
  logic [31:0]           ext_word0, ext_word1, ext_result, rdata_nxt;

  assign rd_addr0 = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign rd_addr1 = rd_addr0 + ADDR_WIDTH'(4);
  assign split    = SPLIT_EN && needs_split(mask_q, addr_q[1:0]);
  assign req_mis  = is_misaligned(sign_mask_i, addr_i[1:0]) && !SPLIT_EN;
  assign busy_o   = (state != ST_IDLE);

  // An unserviced misaligned load enters RESP with cnt=1 so its response lands one cycle later
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    accept      = 1'b0;
    cap0        = 1'b0;
    cap1        = 1'b0;
    mem_rd_en_o = 1'b0;
    mem_addr_o  = '0;
    case (state)
      ST_IDLE: begin
        if (req_valid_i) begin
          accept = 1'b1;
          if (req_mis) begin
            state_nxt = ST_RESP;
            cnt_nxt   = 3'd1;
          end else begin
            state_nxt = ST_RD0;
          end
        end
      end
      ST_RD0: begin
        mem_rd_en_o = 1'b1;
        mem_addr_o  = rd_addr0;
        cnt_nxt     = LAT_M1;
        state_nxt   = ST_WAIT0;
      end
      ST_WAIT0: begin
        if (cnt != 3'd0) begin
          cnt_nxt = cnt - 3'd1;
        end else begin
          cap0      = 1'b1;
          state_nxt = split ? ST_RD1 : ST_RESP;
        end
      end
      ST_RD1: begin
        mem_rd_en_o = 1'b1;
        mem_addr_o  = rd_addr1;
        cnt_nxt     = LAT_M1;
        state_nxt   = ST_WAIT1;
      end
      ST_WAIT1: begin
        if (cnt != 3'd0) begin
          cnt_nxt = cnt - 3'd1;
        end else begin
          cap1      = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (cnt != 3'd0)
          cnt_nxt = cnt - 3'd1;
        else
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bypass the word being captured so the result register loads on the same edge
  assign ext_word0 = cap0 ? mem_rdata_i : word0_q;
  assign ext_word1 = cap1 ? mem_rdata_i : word1_q;
  assign done_nxt  = (cap0 && !split) || cap1 || (state == ST_RESP && cnt == 3'd1);
  assign rdata_nxt = mis_q ? 32'd0 : ext_result;

  load_data_extract u_extract (
    .word0     (ext_word0),
    .word1     (ext_word1),
    .offset    (addr_q[1:0]),
    .sign_mask (mask_q),
    .result    (ext_result)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      cnt          <= 3'd0;
      addr_q       <= '0;
      mask_q       <= 3'd0;
      mis_q        <= 1'b0;
      word0_q      <= 32'd0;
      word1_q      <= 32'd0;
      rdata_o      <= 32'd0;
      done_o       <= 1'b0;
      misaligned_o <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      done_o       <= done_nxt;
      misaligned_o <= done_nxt & mis_q;
      if (accept) begin
        addr_q <= addr_i;
        mask_q <= sign_mask_i;
        mis_q  <= req_mis;
      end
      if (cap0)
        word0_q <= mem_rdata_i;
      if (cap1)
        word1_q <= mem_rdata_i;
      if (done_nxt)
        rdata_o <= rdata_nxt;
    end
  end

endmodule

// File: tb/tb_load_data_unit.sv
// Scoreboarded bench for load_data_unit with MEM_LATENCY=1 and a two-word memory model.
module tb_load_data_unit;

  localparam int LAT = 1;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic [31:0] addr_i = 32'd0;
  logic [2:0]  sign_mask_i = 3'd0;
  logic        mem_rd_en_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_rdata_i = 32'd0;
  logic [31:0] rdata_o;
  logic        done_o;
  logic        busy_o;
  logic        misaligned_o;

  load_data_unit #(.MEM_LATENCY(LAT), .ADDR_WIDTH(32)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .addr_i       (addr_i),
    .sign_mask_i  (sign_mask_i),
    .mem_rd_en_o  (mem_rd_en_o),
    .mem_addr_o   (mem_addr_o),
    .mem_rdata_i  (mem_rdata_i),
    .rdata_o      (rdata_o),
    .done_o       (done_o),
    .busy_o       (busy_o),
    .misaligned_o (misaligned_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    case (a)
      32'h100: return 32'hDEADBEEF;
      32'h104: return 32'h01234567;
      default: return 32'h0;
    endcase
  endfunction

  // Data is valid only in the cycle after the strobe; filler elsewhere
  always @(posedge clk_i) begin
    if (mem_rd_en_o) mem_rdata_i <= mem_read(mem_addr_o);
    else             mem_rdata_i <= 32'hA5A5A5A5;
  end

  typedef struct { logic [31:0] addr; int cyc; } rd_t;
  typedef struct { logic [31:0] data; logic mis; int cyc; } exp_t;
  rd_t  rd_q[$];
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk_i) begin
    rd_t  r;
    exp_t e;
    if (mem_rd_en_o) begin
      if (rd_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_read: got addr %h, expected no read (cycle %0d)", mem_addr_o, cyc);
      end else begin
        r = rd_q.pop_front();
        check("rd_addr", mem_addr_o, r.addr);
        check("rd_cycle", 32'(cyc), 32'(r.cyc));
      end
    end
    if (done_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_done: got done rdata %h, expected no done (cycle %0d)", rdata_o, cyc);
      end else begin
        e = exp_q.pop_front();
        check("rdata", rdata_o, e.data);
        check("misaligned", 32'(misaligned_o), 32'(e.mis));
        check("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else if (misaligned_o) begin
      n_cmp++; n_err++;
      $display("FAIL stray_misaligned: got 1 without done, expected 0 (cycle %0d)", cyc);
    end
  end

  // lat = done cycle relative to the accept cycle; reads are spaced LAT+1 apart
  task automatic issue(input logic [31:0] addr, input logic [2:0] mask, input logic [31:0] data,
                       input logic mis, input int lat, input int nreads, input bit want_done);
    int   c;
    rd_t  r;
    exp_t e;
    @(negedge clk_i);
    req_valid_i = 1'b1;
    addr_i      = addr;
    sign_mask_i = mask;
    c = cyc;
    for (int i = 0; i < nreads; i++) begin
      r.addr = {addr[31:2], 2'b00} + 32'(4 * i);
      r.cyc  = c + 1 + i * (LAT + 1);
      rd_q.push_back(r);
    end
    if (want_done) begin
      e.data = data; e.mis = mis; e.cyc = c + lat;
      exp_q.push_back(e);
    end
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rd_q.size() != 0 || busy_o) && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 40) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: got %0d responses outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
      rd_q.delete();
    end
    check({name, "_idle_busy"}, 32'(busy_o), 32'd0);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_busy"}, 32'(busy_o), 32'd0);
    check({name, "_done"}, 32'(done_o), 32'd0);
    check({name, "_rd_en"}, 32'(mem_rd_en_o), 32'd0);
    check({name, "_mis"}, 32'(misaligned_o), 32'd0);
    check({name, "_rdata"}, rdata_o, 32'd0);
    check({name, "_mem_addr"}, mem_addr_o, 32'd0);
  endtask

  initial begin
    int c;
    rd_t  r;
    exp_t e;

    repeat (3) @(negedge clk_i);
    check_quiet("reset");
    rst_i = 1'b0;
    @(negedge clk_i);

    issue(32'h103, 3'b100, 32'hFFFFFFDE, 1'b0, 2 + LAT, 1, 1'b1); drain("lb_103");
    issue(32'h103, 3'b000, 32'h000000DE, 1'b0, 2 + LAT, 1, 1'b1); drain("lbu_103");
    issue(32'h102, 3'b101, 32'hFFFFDEAD, 1'b0, 2 + LAT, 1, 1'b1); drain("lh_102");
    issue(32'h102, 3'b001, 32'h0000DEAD, 1'b0, 2 + LAT, 1, 1'b1); drain("lhu_102");
    issue(32'h100, 3'b101, 32'hFFFFBEEF, 1'b0, 2 + LAT, 1, 1'b1); drain("lh_100");
    issue(32'h101, 3'b100, 32'hFFFFFFBE, 1'b0, 2 + LAT, 1, 1'b1); drain("lb_101");
    issue(32'h100, 3'b000, 32'h000000EF, 1'b0, 2 + LAT, 1, 1'b1); drain("lbu_100");

    // LW with a second request held during busy: it must not start a read
    @(negedge clk_i);
    req_valid_i = 1'b1; addr_i = 32'h100; sign_mask_i = 3'b010;
    c = cyc;
    r.addr = 32'h100; r.cyc = c + 1; rd_q.push_back(r);
    e.data = 32'hDEADBEEF; e.mis = 1'b0; e.cyc = c + 2 + LAT; exp_q.push_back(e);
    @(negedge clk_i);
    check("lw_busy_c1", 32'(busy_o), 32'd1);
    addr_i = 32'h104;
    @(negedge clk_i);
    check("lw_busy_c2", 32'(busy_o), 32'd1);
    req_valid_i = 1'b0;
    drain("lw_100");
    check("lw_rdata_held", rdata_o, 32'hDEADBEEF);

    issue(32'h104, 3'b110, 32'h01234567, 1'b0, 2 + LAT, 1, 1'b1); drain("lw_104_sign");

`ifdef LOAD_MISALIGN_SPLIT_EN
    issue(32'h101, 3'b010, 32'h67DEADBE, 1'b0, 3 + 2 * LAT, 2, 1'b1); drain("lw_101_split");
    issue(32'h103, 3'b101, 32'h000067DE, 1'b0, 3 + 2 * LAT, 2, 1'b1); drain("lh_103_split");
    issue(32'h101, 3'b001, 32'h0000ADBE, 1'b0, 2 + LAT, 1, 1'b1);     drain("lhu_101_single");
`else
    issue(32'h101, 3'b010, 32'h0, 1'b1, 2, 0, 1'b1); drain("lw_101_mis");
    issue(32'h103, 3'b101, 32'h0, 1'b1, 2, 0, 1'b1); drain("lh_103_mis");
    issue(32'h101, 3'b001, 32'h0, 1'b1, 2, 0, 1'b1); drain("lhu_101_mis");
    issue(32'h100, 3'b010, 32'hDEADBEEF, 1'b0, 2 + LAT, 1, 1'b1); drain("lw_after_mis");
`endif

    // Reset in WAIT0: the read goes out but no response may follow
    issue(32'h100, 3'b010, 32'h0, 1'b0, 0, 1, 1'b0);
    @(negedge clk_i);
    check("rst_pre_busy", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check_quiet("mid_reset");
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (6) @(negedge clk_i);
    check("post_reset_busy", 32'(busy_o), 32'd0);
    check("post_reset_rd_pending", 32'(rd_q.size()), 32'd0);

    issue(32'h104, 3'b010, 32'h01234567, 1'b0, 2 + LAT, 1, 1'b1); drain("lw_104_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/load_data_unit.md
Name: load_data_unit

Overview:
Sequential load path for LB/LBU/LH/LHU/LW between the execute stage and the synchronous data memory read port.
- Accepts one load request, issues word-aligned memory reads, waits the fixed memory latency, then extracts the byte/halfword/word with sign or zero extension.
- Returns a registered result with a one-cycle done pulse.
- Drives busy_o so the pipeline stalls while a load is in flight.

Parameters:
MEM_LATENCY, 1, cycles from mem_rd_en_o high to mem_rdata_i valid (legal range 1..7)
ADDR_WIDTH, 32, byte address width

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-high
req_valid_i  input  1  load request; accepted only in IDLE
addr_i  input  ADDR_WIDTH  byte address
sign_mask_i  input  3  [1:0]: 00 byte, 01 halfword, 1x word; [2]: 1 = sign-extend, 0 = zero-extend
mem_rd_en_o  output  1  memory read strobe, one cycle per read
mem_addr_o  output  ADDR_WIDTH  word-aligned read address, bits [1:0] = 0
mem_rdata_i  input  32  memory read data
rdata_o  output  32  extracted load result; held until the next done_o
done_o  output  1  one-cycle pulse, rdata_o valid
busy_o  output  1  high in every state except IDLE
misaligned_o  output  1  high with done_o when the access was misaligned and not serviced

Behaviour:
- Reset: state IDLE; all outputs 0; latched request cleared. Takes effect at any point, including mid-WAIT. Data arriving after reset is ignored.
- Misaligned load: halfword with addr[0]=1, or word with addr[1:0]!=0.
- States: IDLE, RD0, WAIT0, RD1, WAIT1, RESP.
- IDLE: on req_valid_i, latch addr_i and sign_mask_i.
  - Aligned request -> RD0.
  - Misaligned request -> RESP with misaligned_o=1 and rdata_o=0.
- RD0: mem_rd_en_o=1, mem_addr_o={addr[ADDR_WIDTH-1:2],2'b00}. Load the latency counter with MEM_LATENCY-1 -> WAIT0.
- WAIT0: count down. At 0, capture mem_rdata_i into word0 -> RD1 if a split is required (see Optional Feature), otherwise -> RESP.
- RD1/WAIT1: as RD0/WAIT0 with word address +4, wrapping modulo 2^ADDR_WIDTH. Capture into word1.
- RESP: register rdata_o, pulse done_o for one cycle -> IDLE. A new request may be accepted on the cycle after RESP.
- Latency (accept cycle = 0, aligned load): mem_rd_en_o at cycle 1, data sampled at cycle 1+MEM_LATENCY, done_o at cycle 2+MEM_LATENCY. For MEM_LATENCY=1, done_o is at cycle 3.
- Extraction, offset o = addr[1:0]:
  - byte = word0[8o+7:8o]
  - halfword = word0[16*addr[1]+15 : 16*addr[1]]
  - word = word0
  - Extend to 32 bits per sign_mask_i[2]. sign_mask_i[2] is ignored for word loads.
- req_valid_i while busy_o=1 is ignored; there is no queueing and the requester must hold or reissue.
- mem_rdata_i is sampled only in the capture cycle.

Optional Feature:
LOAD_MISALIGN_SPLIT_EN
- Defined: misaligned loads are serviced and misaligned_o stays 0.
  - Halfword at o=1 fits in one word: single read, result word0[23:8].
  - Halfword at o=3, or word at o!=0: two reads (RD0 then RD1). Result = ({word1,word0} >> 8*o) truncated to the access size, then extended.
  - done_o at cycle 3+2*MEM_LATENCY.
- Undefined: misaligned loads get no memory access; done_o at cycle 2 with misaligned_o=1 and rdata_o=0.

Decomposition:
- Shared package/include (rv32i-defines): sign_mask field encodings (size codes, sign bit position) and state encodings for load_data_unit.
- One natural sub-module: load_data_extract. Combinational; takes word0, word1, offset and sign_mask and returns the 32-bit extended result. The FSM, latency counter and registers stay in load_data_unit.

Test Plan:
Setup: MEM_LATENCY=1; mem[0x100]=0xDEADBEEF, mem[0x104]=0x01234567.
- LB (sign_mask 3'b100) addr 0x103 -> one mem_rd_en_o with mem_addr_o=0x100; done_o at cycle 3; rdata_o=0xFFFFFFDE; LBU (3'b000) at the same address -> 0x000000DE.
- LH (3'b101) / LHU (3'b001) addr 0x102 -> 0xFFFFDEAD / 0x0000DEAD; LH addr 0x100 -> 0xFFFFBEEF.
- LW (3'b010) addr 0x100 -> 0xDEADBEEF; busy_o high cycles 1-2; a second req_valid_i at cycle 1 is ignored (no extra mem_rd_en_o).
- LW addr 0x101, feature undefined -> no mem_rd_en_o; done_o and misaligned_o at cycle 2; rdata_o=0.
- LW addr 0x101, LOAD_MISALIGN_SPLIT_EN defined -> reads 0x100 then 0x104; done_o at cycle 5; rdata_o=0x67DEADBE; misaligned_o=0.
- rst_i asserted during WAIT0, then a late mem_rdata_i -> state IDLE, all outputs 0, no done_o; a fresh LW addr 0x104 afterwards -> 0x01234567.
